// File: rtl/codec_cfg_pkg.sv
// Codec configuration package: FSM states, WM8731 register map,
// init register table and command word helpers.
package codec_cfg_pkg;

  typedef enum logic [2:0] {
    S_POR_WAIT,
    S_ISSUE,
    S_WAIT_RSP,
    S_GAP,
    S_DONE,
    S_VOL_ISSUE,
    S_VOL_WAIT,
    S_ERROR
  } state_t;

  localparam int N_REGS = 11;

  localparam logic [6:0] R_LLINEIN = 7'd0;
  localparam logic [6:0] R_RLINEIN = 7'd1;
  localparam logic [6:0] R_LHPOUT  = 7'd2;
  localparam logic [6:0] R_RHPOUT  = 7'd3;
  localparam logic [6:0] R_ANALOG  = 7'd4;
  localparam logic [6:0] R_DIGITAL = 7'd5;
  localparam logic [6:0] R_POWER   = 7'd6;
  localparam logic [6:0] R_IFACE   = 7'd7;
  localparam logic [6:0] R_SAMPLE  = 7'd8;
  localparam logic [6:0] R_ACTIVE  = 7'd9;
  localparam logic [6:0] R_RESET   = 7'd15;

  function automatic logic [15:0] pack_word(
    input logic [6:0] reg_addr,
    input logic [8:0] value
  );
    return {reg_addr, value};
  endfunction

  // LRHPBOTH=1 writes both channels, LZCEN=0
  function automatic logic [15:0] vol_word(
    input logic [6:0] vol
  );
    return pack_word(R_LHPOUT, {1'b1, 1'b0, vol});
  endfunction

  localparam logic [15:0] REG_TABLE [N_REGS] = '{
    pack_word(R_RESET,   9'h000),
    pack_word(R_POWER,   9'h007),
    pack_word(R_LLINEIN, 9'h017),
    pack_word(R_RLINEIN, 9'h017),
    pack_word(R_LHPOUT,  9'h179),
    pack_word(R_RHPOUT,  9'h079),
    pack_word(R_ANALOG,  9'h012),
    pack_word(R_DIGITAL, 9'h000),
    pack_word(R_IFACE,   9'h002),
    pack_word(R_SAMPLE,  9'h001),
    pack_word(R_ACTIVE,  9'h001)
  };

endpackage

// File: rtl/codec_config_sequencer_delay_counter.sv
// Up-counter from zero that saturates at a target; expired
// flags that the target has been reached.
module delay_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic [W-1:0] target,
  output logic         expired
);

  logic [W-1:0] cnt;

  assign expired = (cnt == target);

  // count up while not expired, clear restarts from zero
  always_ff @(posedge clk) begin
    if (!reset_n || clear) cnt <= '0;
    else if (!expired)     cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/codec_config_sequencer.sv
// WM8731 bring-up sequencer: POR delay, register table writes
// with NACK retry, then runtime headphone volume writes.
module codec_config_sequencer
  import codec_cfg_pkg::*;
#(
  parameter int         POR_DELAY_CYCLES = 50000,
  parameter int         GAP_CYCLES       = 500,
  parameter int         MAX_RETRY        = 3,
  parameter logic [7:0] DEV_ADDR         = 8'h34
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        restart,
  input  logic        vol_update,
  input  logic [6:0]  vol,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [7:0]  cmd_dev,
  output logic [15:0] cmd_data,
  input  logic        rsp_valid,
  input  logic        rsp_nack,
  output logic        init_done,
  output logic        init_error,
  output logic        busy
);

  localparam int MAXD = (POR_DELAY_CYCLES > GAP_CYCLES) ?
                        POR_DELAY_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAXD + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CW-1:0] POR_T   = CW'(POR_DELAY_CYCLES);
  localparam logic [CW-1:0] GAP_T   = CW'(GAP_CYCLES);
  localparam logic [RW-1:0] MAX_R   = RW'(MAX_RETRY);
  localparam logic [3:0]    END_IDX = 4'(N_REGS);

  state_t        state;
  logic [3:0]    index;
  logic [RW-1:0] retry;
  logic          vol_pending;
  logic          vol_mode;
  logic [6:0]    vol_latched;
  logic          ctr_clear;
  logic          ctr_expired;
  logic [CW-1:0] ctr_target;

  assign cmd_dev    = DEV_ADDR;
  assign ctr_clear  = restart ||
                      !((state == S_POR_WAIT) || (state == S_GAP));
  assign ctr_target = (state == S_POR_WAIT) ? POR_T : GAP_T;

  delay_counter #(.W(CW)) u_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (ctr_clear),
    .target  (ctr_target),
    .expired (ctr_expired)
  );

  // sequencer FSM with registered handshake and status outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_POR_WAIT;
      index       <= '0;
      retry       <= '0;
      vol_pending <= 1'b0;
      vol_mode    <= 1'b0;
      vol_latched <= '0;
      cmd_valid   <= 1'b0;
      cmd_data    <= '0;
      init_done   <= 1'b0;
      init_error  <= 1'b0;
      busy        <= 1'b1;
    end else begin
      if (restart) begin
        state      <= S_POR_WAIT;
        index      <= '0;
        retry      <= '0;
        vol_mode   <= 1'b0;
        cmd_valid  <= 1'b0;
        init_done  <= 1'b0;
        init_error <= 1'b0;
        busy       <= 1'b1;
      end else begin
        unique case (state)
          S_POR_WAIT: begin
            if (ctr_expired) begin
              state     <= S_ISSUE;
              cmd_valid <= 1'b1;
              cmd_data  <= REG_TABLE[index];
            end
          end
          S_ISSUE, S_VOL_ISSUE: begin
            if (cmd_ready) begin
              cmd_valid <= 1'b0;
              state     <= (state == S_ISSUE) ? S_WAIT_RSP : S_VOL_WAIT;
            end
          end
          S_WAIT_RSP, S_VOL_WAIT: begin
            if (rsp_valid) begin
              if (!rsp_nack) begin
                retry <= '0;
                state <= S_GAP;
                if (state == S_WAIT_RSP) index <= index + 4'd1;
              end else if (retry < MAX_R) begin
                retry <= retry + RW'(1);
                state <= S_GAP;
              end else begin
                state      <= S_ERROR;
                vol_mode   <= 1'b0;
                init_done  <= 1'b0;
                init_error <= 1'b1;
                busy       <= 1'b0;
              end
            end
          end
          S_GAP: begin
            if (ctr_expired) begin
              if (vol_mode) begin
                if (retry != '0) begin
                  state     <= S_VOL_ISSUE;
                  cmd_valid <= 1'b1;
                end else begin
                  state    <= S_DONE;
                  vol_mode <= 1'b0;
                  busy     <= 1'b0;
                end
              end else if (index == END_IDX) begin
                state     <= S_DONE;
                init_done <= 1'b1;
                busy      <= 1'b0;
              end else begin
                state     <= S_ISSUE;
                cmd_valid <= 1'b1;
                cmd_data  <= REG_TABLE[index];
              end
            end
          end
          S_DONE: begin
            if (vol_pending) begin
              vol_pending <= 1'b0;
              vol_mode    <= 1'b1;
              cmd_data    <= vol_word(vol_latched);
              cmd_valid   <= 1'b1;
              busy        <= 1'b1;
              state       <= S_VOL_ISSUE;
            end
          end
          S_ERROR: begin
            state <= S_ERROR;
          end
          default: state <= S_POR_WAIT;
        endcase
      end
      if (vol_update) begin
        vol_pending <= 1'b1;
        vol_latched <= vol;
      end
    end
  end

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Scoreboard bench for codec_config_sequencer: directed
// scenarios against a simple I2C master model.
module tb_codec_config_sequencer;

  localparam int RSP_LAT = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        restart;
  logic        vol_update;
  logic [6:0]  vol;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_dev;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_nack;
  logic        init_done;
  logic        init_error;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_q [$];
  logic [15:0] words [11] = '{
    16'h1E00, 16'h0C07, 16'h0017, 16'h0217, 16'h0579, 16'h0679,
    16'h0812, 16'h0A00, 16'h0E02, 16'h1001, 16'h1201
  };

  int          rsp_timer  = 0;
  logic [15:0] last_word  = '0;
  logic [15:0] held_word  = '0;
  logic [15:0] nack_word  = '0;
  int          nack_left  = 0;
  logic [15:0] stall_word = '0;
  int          stall_left = 0;
  logic        stalling   = 1'b0;

  codec_config_sequencer #(
    .POR_DELAY_CYCLES (20),
    .GAP_CYCLES       (4),
    .MAX_RETRY        (3),
    .DEV_ADDR         (8'h34)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .restart    (restart),
    .vol_update (vol_update),
    .vol        (vol),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dev    (cmd_dev),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_nack   (rsp_nack),
    .init_done  (init_done),
    .init_error (init_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_range(input int from, input int to);
    for (int i = from; i <= to; i++) exp_q.push_back(words[i]);
  endtask

  task automatic slot();
    @(posedge clk); #2;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    slot();
    restart = 1'b0;
  endtask

  task automatic pulse_vol(input logic [6:0] v);
    vol = v;
    vol_update = 1'b1;
    slot();
    vol_update = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!(exp_q.size() == 0 && !busy && init_done) && n < 2000) begin
      slot();
      n++;
    end
    check({name, "_done_timeout"}, 32'(n < 2000), 32'd1);
  endtask

  // I2C master model: ready, stall, delayed response, NACK injection
  initial begin : master
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_nack  = 1'b0;
    forever begin
      slot();
      rsp_valid = 1'b0;
      rsp_nack  = 1'b0;
      if (rsp_timer > 0) begin
        rsp_timer--;
        if (rsp_timer == 0) begin
          rsp_valid = 1'b1;
          if (last_word == nack_word && nack_left > 0) begin
            rsp_nack = 1'b1;
            nack_left--;
          end
        end
      end
      if (cmd_ready) begin
        rsp_timer = RSP_LAT;
        last_word = held_word;
      end
      cmd_ready = 1'b0;
      if (stalling) begin
        check("stall_valid", 32'(cmd_valid), 32'd1);
        check("stall_data", 32'(cmd_data), 32'h0217);
      end
      if (cmd_valid) begin
        if (stall_left > 0 && (stalling || cmd_data == stall_word)) begin
          stalling = 1'b1;
          stall_left--;
        end else begin
          stalling  = 1'b0;
          cmd_ready = 1'b1;
          held_word = cmd_data;
        end
      end else begin
        stalling = 1'b0;
      end
    end
  end

  // scoreboard monitor: every accepted command pops one expected word
  initial begin : monitor
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (reset_n && cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_cmd: got 0x%0h expected none", cmd_data);
        end else begin
          e = exp_q.pop_front();
          check("cmd_data", 32'(cmd_data), 32'(e));
          check("cmd_dev", 32'(cmd_dev), 32'h34);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    reset_n    = 1'b0;
    restart    = 1'b0;
    vol_update = 1'b0;
    vol        = '0;
    repeat (3) slot();

    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_cmd_dev", 32'(cmd_dev), 32'h34);
    check("rst_cmd_data", 32'(cmd_data), 32'h0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_init_error", 32'(init_error), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);

    // first init: stall on index 3, two NACKs on index 5, volume updates
    stall_word = 16'h0217;
    stall_left = 5;
    nack_word  = 16'h0679;
    nack_left  = 2;
    push_range(0, 5);
    push_range(5, 5);
    push_range(5, 10);
    exp_q.push_back(16'h0560);
    reset_n = 1'b1;

    n = 0;
    while (!cmd_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("por_latency", 32'(n), 32'd21);
    check("first_word", 32'(cmd_data), 32'h1E00);

    repeat (30) slot();
    pulse_vol(7'h50);
    repeat (40) slot();
    check("vol_before_done", 32'(init_done), 32'd0);
    pulse_vol(7'h60);
    wait_done("init1");
    repeat (20) slot();
    check("init1_done", 32'(init_done), 32'd1);
    check("init1_busy", 32'(busy), 32'd0);
    check("init1_error", 32'(init_error), 32'd0);
    check("init1_q_empty", 32'(exp_q.size()), 32'd0);

    // restart while waiting for the response of index 7
    pulse_restart();
    check("rs_done_clr", 32'(init_done), 32'd0);
    check("rs_busy", 32'(busy), 32'd1);
    push_range(0, 7);
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      slot();
      n++;
    end
    check("rs_reach_idx7", 32'(n < 1000), 32'd1);
    pulse_restart();
    push_range(0, 10);
    repeat (8) slot();
    check("rs_mid_done", 32'(init_done), 32'd0);
    wait_done("init2");
    check("init2_done", 32'(init_done), 32'd1);

    // four NACKs on index 5 exhaust the retries
    pulse_restart();
    nack_word = 16'h0679;
    nack_left = 4;
    push_range(0, 5);
    repeat (3) push_range(5, 5);
    n = 0;
    while (!init_error && n < 1000) begin
      slot();
      n++;
    end
    check("err_timeout", 32'(n < 1000), 32'd1);
    check("err_busy", 32'(busy), 32'd0);
    check("err_done", 32'(init_done), 32'd0);
    repeat (30) slot();
    check("err_no_cmd", 32'(cmd_valid), 32'd0);
    check("err_q_empty", 32'(exp_q.size()), 32'd0);
    check("err_hold", 32'(init_error), 32'd1);

    // recovery from ERROR
    pulse_restart();
    check("rec_err_clr", 32'(init_error), 32'd0);
    push_range(0, 10);
    wait_done("init3");
    check("init3_done", 32'(init_done), 32'd1);
    check("init3_error", 32'(init_error), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/codec_config_sequencer.md
Name: codec_config_sequencer

Overview:
- Drives the audio codec bring-up and runtime control over the shared I2C master.
- After reset, waits a power-on delay, then writes a fixed WM8731 register table over a command/response handshake, retrying any write that is NACKed.
- After init it services headphone-volume updates derived from the switch/button controller.
- Sits between buttons_controller, the I2C master, and status LEDs/sound_gen enable.

Parameters:
- POR_DELAY_CYCLES, 50000, idle cycles after reset before the first write (1 ms at 50 MHz).
- GAP_CYCLES, 500, idle cycles between completing one write and issuing the next.
- MAX_RETRY, 3, re-issues allowed per write after a NACK before giving up.
- DEV_ADDR, 8'h34, codec I2C write address byte.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- restart  in  1  1-cycle pulse; reruns the full init table.
- vol_update  in  1  1-cycle pulse; requests a headphone volume write.
- vol  in  7  volume code, sampled on vol_update.
- cmd_valid  out  1  command valid to the I2C master.
- cmd_ready  in  1  I2C master accepts the command.
- cmd_dev  out  8  device address byte.
- cmd_data  out  16  {reg[6:0], value[8:0]}.
- rsp_valid  in  1  transfer finished (1 cycle).
- rsp_nack  in  1  qualifies rsp_valid; 1 = NACK.
- init_done  out  1  table written successfully.
- init_error  out  1  retries exhausted.
- busy  out  1  high in every state except DONE and ERROR.

Behaviour:
- Reset values: cmd_valid=0, cmd_dev=DEV_ADDR, cmd_data=0, init_done=0, init_error=0, busy=1. Internally: state=POR_WAIT, index=0, retry=0, delay counter=0, vol_pending=0.
- Register table (shared package constant, 11 entries, index 0..10):
  - R15=0x000, R6=0x007, R0=0x017, R1=0x017, R2=0x179, R3=0x079
  - R4=0x012, R5=0x000, R7=0x002, R8=0x001, R9=0x001
  - Resulting cmd_data words: 0x1E00, 0x0C07, 0x0017, 0x0217, 0x0579, 0x0679, 0x0812, 0x0A00, 0x0E02, 0x1001, 0x1201.
- States:
  - POR_WAIT: count POR_DELAY_CYCLES, then go to ISSUE.
  - ISSUE: cmd_valid=1 with cmd_data=table[index]. cmd_data/cmd_dev stay stable while cmd_valid && !cmd_ready. On the cmd_valid && cmd_ready cycle, drop cmd_valid the next cycle and go to WAIT_RSP.
  - WAIT_RSP: on rsp_valid && !rsp_nack, clear retry and go to GAP. On rsp_valid && rsp_nack:
    - retry<MAX_RETRY: retry++, go to GAP, reissue the same index.
    - else go to ERROR.
  - GAP: count GAP_CYCLES. Then go to ISSUE for the next or retried index. If the table is finished, go to DONE; if the volume write is finished, return to DONE.
  - DONE: init_done=1, busy=0. If vol_pending, clear it, load cmd_data=0x0500|vol_latched (R2, LRHPBOTH=1, LZCEN=0), and go to VOL_ISSUE.
  - VOL_ISSUE / VOL_WAIT: same handshake and retry rules as ISSUE/WAIT_RSP. Exhausted retries go to ERROR; success goes to GAP, then DONE.
  - ERROR: init_error=1, busy=0, init_done=0. Holds until restart or reset.
- Command timing: issue latency from GAP expiry to cmd_valid is 1 cycle. rsp_valid arriving outside WAIT_RSP/VOL_WAIT is ignored.
- vol_update in any state: latch vol into vol_latched, set vol_pending. Last request wins; pending writes never queue beyond one.
- restart:
  - From any state: abandon the current command, clear index, retry, init_done and init_error, and go to POR_WAIT. vol_pending is kept.
  - Mid-transfer restart does not wait for rsp_valid; a stale rsp_valid is discarded because POR_WAIT ignores it.
- restart and vol_update in the same cycle: both take effect; the volume is applied after the new init completes.
- reset_n low overrides everything on the next edge.
- Counters are sized with $clog2 of the largest parameter. retry is $clog2(MAX_RETRY+1) bits wide. index is 4 bits; 11 entries means index wraps at 10 → DONE.

Decomposition:
- codec_cfg_pkg:
  - state enum
  - REG_TABLE constant array and N_REGS=11
  - register address constants (R_LHPOUT=2, R_RESET=15, ...)
  - function pack_word(reg, value) returning 16 bits
- One sub-module, delay_counter: load/count/expired, reused for POR_WAIT and GAP.

Test Plan:
- Reset with POR_DELAY_CYCLES=20, GAP_CYCLES=4, always-ACK master -> first cmd_valid exactly 21 cycles after reset release with cmd_data=0x1E00, then 11 commands in table order, then init_done=1 and busy=0.
- cmd_ready held low for 5 cycles on index 3 -> cmd_valid and cmd_data=0x0217 stable throughout; the command is accepted exactly once.
- NACK twice on index 5 (0x0679), then ACK -> the same word is issued 3 times and the sequence completes; with MAX_RETRY=3, four NACKs -> init_error=1, busy=0, no further cmd_valid.
- vol_update with vol=0x50 during init, then vol=0x60 before DONE -> exactly one extra write, 0x0560, after index 10 completes.
- restart asserted while waiting for the response to index 7 -> the late rsp_valid is ignored; after POR delay the sequence restarts at 0x1E00 with init_done=0.
- From ERROR, restart -> init_error clears and a full successful init sets init_done=1.
